// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, long-latency results drain from a FIFO.
// Optional RF_WB_LU_BYPASS_EN lets a long-latency result skip an empty, idle FIFO.
module rf_writeback_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          core_valid,
  input  logic [4:0]                    core_rd,
  input  logic [31:0]                   core_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_rd,
  input  logic [31:0]                   lu_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    A1,
  input  logic [4:0]                    A2,
  output logic                          hazard1,
  output logic                          hazard2,
  output logic                          rf_we,
  output logic [4:0]                    rf_A3,
  output logic [31:0]                   rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic          rf_we_reg;
  logic [4:0]    rf_a3_reg;
  logic [31:0]   rf_wd_reg;

  logic [31:0]   busy_reg;
  logic [31:0]   busy_next;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign lu_ready   = !fifo_full;

`ifdef RF_WB_LU_BYPASS_EN
  // Idle output stage and nothing queued: the offered result goes straight out.
  assign bypass = !core_valid && fifo_empty && lu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push      = lu_valid && lu_ready && !bypass;
  assign pop       = !core_valid && !fifo_empty;
  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= lu_rd;
      data_mem[wr_ptr_reg] <= lu_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_reg <= 1'b0;
      rf_a3_reg <= '0;
      rf_wd_reg <= '0;
    end else if (core_valid) begin
      rf_we_reg <= (core_rd != 5'd0);
      rf_a3_reg <= core_rd;
      rf_wd_reg <= core_data;
    end else if (pop) begin
      rf_we_reg <= (head_rd != 5'd0);
      rf_a3_reg <= head_rd;
      rf_wd_reg <= head_data;
    end else if (bypass) begin
      rf_we_reg <= (lu_rd != 5'd0);
      rf_a3_reg <= lu_rd;
      rf_wd_reg <= lu_data;
    end else begin
      rf_we_reg <= 1'b0;
    end
  end

  // Clear before set so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_next = busy_reg;
    if (pop)
      busy_next[head_rd] = 1'b0;
    if (bypass)
      busy_next[lu_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  // The output-stage compare covers the cycle between busy clearing and the RF update.
  assign hazard1 = (A1 != 5'd0) && (busy_reg[A1] || (rf_we_reg && (rf_a3_reg == A1)));
  assign hazard2 = (A2 != 5'd0) && (busy_reg[A2] || (rf_we_reg && (rf_a3_reg == A2)));

  assign rf_we      = rf_we_reg;
  assign rf_A3      = rf_a3_reg;
  assign rf_wd      = rf_wd_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: scoreboard of long-latency writes plus per-scenario checks.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_valid;
  logic [4:0]  core_rd;
  logic [31:0] core_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        hazard1;
  logic        hazard2;
  logic        rf_we;
  logic [4:0]  rf_A3;
  logic [31:0] rf_wd;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

`ifdef RF_WB_LU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  rf_writeback_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .core_valid(core_valid), .core_rd(core_rd), .core_data(core_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .A1(A1), .A2(A2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_A3(rf_A3), .rf_wd(rf_wd), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Expected long-latency writes {rd, data}, in acceptance order.
  logic [36:0] lu_q[$];
  logic        core_prev = 1'b0;
  logic [4:0]  core_prev_rd = '0;
  logic [31:0] core_prev_data = '0;

  // Mid-cycle monitor: check the write produced by the previous edge, then record this cycle's stimulus.
  always @(negedge clk) begin
    logic [36:0] exp_e;
    if (!resetn) begin
      core_prev = 1'b0;
    end else begin
      if (core_prev) begin
        checks++;
        if (core_prev_rd != 5'd0) begin
          if (rf_we !== 1'b1 || rf_A3 !== core_prev_rd || rf_wd !== core_prev_data) begin
            errors++;
            $display("FAIL core_wb: got we=%0b rd=%0d wd=%h, want we=1 rd=%0d wd=%h",
                     rf_we, rf_A3, rf_wd, core_prev_rd, core_prev_data);
          end
        end else if (rf_we !== 1'b0) begin
          errors++;
          $display("FAIL core_wb_x0: got we=%0b, want we=0", rf_we);
        end
      end else if (rf_we === 1'b1) begin
        checks++;
        if (lu_q.size() == 0) begin
          errors++;
          $display("FAIL lu_wb_unexpected: got rd=%0d wd=%h, want no write", rf_A3, rf_wd);
        end else begin
          exp_e = lu_q.pop_front();
          if (rf_A3 !== exp_e[36:32] || rf_wd !== exp_e[31:0]) begin
            errors++;
            $display("FAIL lu_wb: got rd=%0d wd=%h, want rd=%0d wd=%h",
                     rf_A3, rf_wd, exp_e[36:32], exp_e[31:0]);
          end else begin
            $display("lu write rd=%0d wd=%h", rf_A3, rf_wd);
          end
        end
      end
      core_prev      = core_valid;
      core_prev_rd   = core_rd;
      core_prev_data = core_data;
      if (lu_valid && lu_ready && lu_rd != 5'd0)
        lu_q.push_back({lu_rd, lu_data});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    core_valid = 0; core_rd = 0; core_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0; A1 = 0; A2 = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (lu_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (lu_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending writes, want 0", lu_q.size());
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    for (int i = 0; i < 4; i++) begin
      core_valid = 1'($urandom); core_rd = 5'($urandom); core_data = $urandom;
      lu_valid = 1'($urandom); lu_rd = 5'($urandom); lu_data = $urandom;
      issue_valid = 1'($urandom); issue_rd = 5'($urandom);
      A1 = 5'($urandom); A2 = 5'($urandom);
      tick();
      checks++;
      if (rf_we !== 0 || fifo_count !== 0 || lu_ready !== 1 || hazard1 !== 0 || hazard2 !== 0) begin
        errors++;
        $display("FAIL reset_hold: got we=%0b cnt=%0d rdy=%0b hz=%0b%0b, want 0 0 1 00",
                 rf_we, fifo_count, lu_ready, hazard1, hazard2);
      end
    end
    idle_inputs();
    checks++;
    if (rf_A3 !== 0 || rf_wd !== 0) begin
      errors++;
      $display("FAIL reset_out: got rd=%0d wd=%h, want 0 0", rf_A3, rf_wd);
    end
    resetn = 1;
    tick();
    A1 = 5'd7; A2 = 5'd31;
    tick();
    checks++;
    if (rf_we !== 0 || fifo_count !== 0 || lu_ready !== 1 || hazard1 !== 0 || hazard2 !== 0) begin
      errors++;
      $display("FAIL reset_release: got we=%0b cnt=%0d rdy=%0b hz=%0b%0b, want 0 0 1 00",
               rf_we, fifo_count, lu_ready, hazard1, hazard2);
    end
    idle_inputs();
    $display("reset test done");
  endtask

  task automatic test_core_write;
    core_valid = 1; core_rd = 5'd5; core_data = 32'hDEADBEEF;
    tick();
    core_rd = 5'd0; core_data = 32'h12345678;
    checks++;
    if (rf_we !== 1 || rf_A3 !== 5 || rf_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_rd5: got we=%0b rd=%0d wd=%h, want 1 5 deadbeef", rf_we, rf_A3, rf_wd);
    end
    tick();
    core_rd = 5'd6; core_data = 32'hA5A5_0006;
    checks++;
    if (rf_we !== 0) begin
      errors++;
      $display("FAIL core_rd0: got we=%0b, want 0", rf_we);
    end
    tick();
    core_valid = 0;
    tick();
    checks++;
    if (rf_we !== 0 || rf_A3 !== 5'd6 || rf_wd !== 32'hA5A5_0006) begin
      errors++;
      $display("FAIL core_hold: got we=%0b rd=%0d wd=%h, want 0 6 a5a50006", rf_we, rf_A3, rf_wd);
    end
    idle_inputs();
    $display("core write test done");
  endtask

  task automatic test_scoreboard;
    bit seen = 0;
    issue_valid = 1; issue_rd = 5'd7; A1 = 5'd7; A2 = 5'd0;
    tick();
    issue_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hazard1 !== 1 || hazard2 !== 0) begin
        errors++;
        $display("FAIL sb_busy: got hz1=%0b hz2=%0b, want 1 0", hazard1, hazard2);
      end
      tick();
    end
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h0000_7777;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      lu_valid = 0;
      checks++;
      if (hazard1 !== 1 || hazard2 !== 0) begin
        errors++;
        $display("FAIL sb_pending: got hz1=%0b hz2=%0b, want 1 0", hazard1, hazard2);
      end
      if (rf_we === 1'b1 && rf_A3 === 5'd7) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sb_timeout: got no rd=7 write, want one");
    end
    tick();
    checks++;
    if (hazard1 !== 0) begin
      errors++;
      $display("FAIL sb_clear: got hz1=%0b, want 0", hazard1);
    end
    idle_inputs();
    drain();
    $display("scoreboard test done");
  endtask

  task automatic test_priority;
    int  k = 1;
    bit  acc;
    core_valid = 1;
    lu_valid = 1; lu_rd = 5'(k); lu_data = 32'h100 + k;
    for (int i = 0; i < 6; i++) begin
      core_rd = 5'(10 + i); core_data = 32'hC000_0000 + i;
      checks++;
      if (fifo_count !== 3'((i < 4) ? i : 4) || lu_ready !== (i < 4)) begin
        errors++;
        $display("FAIL prio_fill%0d: got cnt=%0d rdy=%0b, want cnt=%0d rdy=%0b",
                 i, fifo_count, lu_ready, (i < 4) ? i : 4, (i < 4));
      end
      acc = lu_ready;
      tick();
      if (acc) begin
        k++;
        lu_rd = 5'(k); lu_data = 32'h100 + k;
      end
    end
    core_valid = 0; core_rd = 0; core_data = 0;
    for (int j = 1; j <= 5; j++) begin
      acc = lu_valid && lu_ready;
      tick();
      if (acc) lu_valid = 0;
      checks++;
      if (rf_we !== 1 || rf_A3 !== 5'(j)) begin
        errors++;
        $display("FAIL prio_order%0d: got we=%0b rd=%0d, want 1 %0d", j, rf_we, rf_A3, j);
      end
    end
    idle_inputs();
    drain();
    $display("priority test done");
  endtask

  task automatic test_same_cycle;
    bit seen = 0;
    A1 = 5'd9;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h0909_0909;
    if (BYPASS) begin
      issue_valid = 1;
      tick();
      issue_valid = 0; lu_valid = 0;
    end else begin
      tick();
      lu_valid = 0; issue_valid = 1;
      tick();
      issue_valid = 0;
    end
    checks++;
    if (rf_we !== 1 || rf_A3 !== 5'd9 || hazard1 !== 1) begin
      errors++;
      $display("FAIL setclr_wr: got we=%0b rd=%0d hz1=%0b, want 1 9 1", rf_we, rf_A3, hazard1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (hazard1 !== 1) begin
        errors++;
        $display("FAIL setclr_keep: got hz1=%0b, want 1", hazard1);
      end
    end
    lu_valid = 1; lu_data = 32'h0909_0002;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      lu_valid = 0;
      if (rf_we === 1'b1 && rf_A3 === 5'd9) seen = 1;
    end
    tick();
    checks++;
    if (!seen || hazard1 !== 0) begin
      errors++;
      $display("FAIL setclr_final: got seen=%0b hz1=%0b, want 1 0", seen, hazard1);
    end
    idle_inputs();
    drain();
    $display("same-cycle set/clear test done");
  endtask

  task automatic test_bypass;
    issue_valid = 1; issue_rd = 5'd3; A2 = 5'd3;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd3; lu_data = 32'h3333_0003;
    checks++;
    if (lu_ready !== 1 || hazard2 !== 1) begin
      errors++;
      $display("FAIL byp_pre: got rdy=%0b hz2=%0b, want 1 1", lu_ready, hazard2);
    end
    tick();
    lu_valid = 0;
    checks++;
    if (rf_we !== BYPASS || fifo_count !== (BYPASS ? 3'd0 : 3'd1)) begin
      errors++;
      $display("FAIL byp_n1: got we=%0b cnt=%0d, want we=%0b cnt=%0d",
               rf_we, fifo_count, BYPASS, BYPASS ? 0 : 1);
    end
    if (!BYPASS) begin
      tick();
      checks++;
      if (rf_we !== 1 || rf_A3 !== 5'd3) begin
        errors++;
        $display("FAIL byp_n2: got we=%0b rd=%0d, want 1 3", rf_we, rf_A3);
      end
    end
    idle_inputs();
    drain();
    $display("bypass/latency test done");
  endtask

  task automatic test_reset_mid;
    issue_valid = 1; issue_rd = 5'd12; A1 = 5'd12;
    core_valid = 1; core_rd = 5'd20; core_data = 32'h2020_2020;
    lu_valid = 1; lu_rd = 5'd21; lu_data = 32'h2121_2121;
    tick();
    issue_valid = 0; lu_rd = 5'd22; lu_data = 32'h2222_2222;
    tick();
    lu_valid = 0;
    checks++;
    if (fifo_count !== 3'd2 || hazard1 !== 1) begin
      errors++;
      $display("FAIL midrst_pre: got cnt=%0d hz1=%0b, want 2 1", fifo_count, hazard1);
    end
    #2;
    resetn = 0;
    lu_q.delete();
    #1;
    checks++;
    if (fifo_count !== 0 || rf_we !== 0 || hazard1 !== 0 || lu_ready !== 1) begin
      errors++;
      $display("FAIL midrst_async: got cnt=%0d we=%0b hz1=%0b rdy=%0b, want 0 0 0 1",
               fifo_count, rf_we, hazard1, lu_ready);
    end
    idle_inputs();
    tick();
    resetn = 1;
    A1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fifo_count !== 0 || rf_we !== 0 || hazard1 !== 0) begin
        errors++;
        $display("FAIL midrst_after: got cnt=%0d we=%0b hz1=%0b, want 0 0 0", fifo_count, rf_we, hazard1);
      end
    end
    idle_inputs();
    $display("mid-operation reset test done");
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    test_reset();
    test_core_write();
    test_scoreboard();
    test_priority();
    test_same_cycle();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Arbitrates the single write port of the 32-entry integer register file between two producers: the multicycle core's own writeback (ALU/load/CSR results) and the long-latency M/A unit (divider, multiplier, atomics). Long-latency results are buffered in a small FIFO and drained whenever the core is not writing. A per-register scoreboard tracks outstanding long-latency destinations, so the control FSM can stall on read-after-write hazards. Outputs drive the register file's `we`/`A3`/`wd` inputs directly.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: long-latency result buffer entries; power of two, >= 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `core_valid`  in  1  core writeback this cycle; always accepted, no ready.
- `core_rd`  in  5  core destination register.
- `core_data`  in  32  core writeback value.
- `lu_valid`  in  1  long-latency result offered.
- `lu_ready`  out  1  FIFO can accept; `!full`.
- `lu_rd`  in  5  long-latency destination register.
- `lu_data`  in  32  long-latency result.
- `issue_valid`  in  1  long-latency op issued this cycle; marks `issue_rd` busy.
- `issue_rd`  in  5  destination of the issued op.
- `A1`, `A2`  in  5 each  source registers being decoded.
- `hazard1`, `hazard2`  out  1 each  source has a write not yet visible in the register file.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_A3`  out  5  register-file write address (registered).
- `rf_wd`  out  32  register-file write data (registered).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.

## Operation
- Reset: `rf_we`=0, `rf_A3`=0, `rf_wd`=0, FIFO empty (`fifo_count`=0, `lu_ready`=1), all busy bits clear, `hazard1`/`hazard2`=0.
- FIFO push: `lu_valid && lu_ready`. `lu_valid` held while `lu_ready`=0 must not change payload.
- Output selection each cycle, priority order:
  1. `core_valid`: load output reg with `core_rd`/`core_data`; `rf_we` = (`core_rd`!=0).
  2. else FIFO non-empty: pop head into output reg; `rf_we` = (head rd != 0).
  3. else `rf_we`=0; `rf_A3`/`rf_wd` hold last value.
- Push while full is impossible by handshake. Push and pop in the same cycle: count unchanged. Push into full FIFO with same-cycle pop is NOT permitted (`lu_ready` depends only on count).
- Scoreboard `busy[31:1]` (`busy[0]` constant 0):
  - set on `issue_valid && issue_rd!=0`;
  - cleared for rd of an entry popped from FIFO (case 2);
  - set and clear of same index same cycle: set wins.
- `hazardN` (combinational) = `AN!=0` and (`busy[AN]` or (`rf_we` and `rf_A3`==`AN`)).
- Core writing a register whose busy bit is set is a control-FSM bug; the write is performed, busy is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`; entries drain in arrival order.

## Timing
- Core write: `core_valid` at cycle N -> `rf_we`=1 at N+1 -> register file updated at end of N+1.
- Long-latency write: push at N -> pop at earliest N+1 (if no `core_valid`) -> `rf_we` at N+2; each cycle of `core_valid` delays it by one.
- Busy clears at pop edge; `hazard` remains asserted through the `rf_we` cycle via output-stage compare, drops at N+3.
- Sustained `core_valid` starves the FIFO; `lu_ready` falls when `fifo_count`==`FIFO_DEPTH`.
- Reset asserted mid-operation: immediate (asynchronous) return to reset state; buffered results and busy bits are discarded.

## Configuration
- `RF_WB_LU_BYPASS_EN` defined: when FIFO empty, `core_valid`=0 and `lu_valid`=1, the result goes straight to the output register (no push), `rf_we` at N+1, busy cleared at that edge; `lu_ready`=1 in that case.
- Not defined: all long-latency results pass through the FIFO (minimum latency 2).

## Test plan
- Reset: hold `resetn`=0 with random inputs -> `rf_we`=0, `fifo_count`=0, `lu_ready`=1, hazards 0; release -> same values.
- Core write: `core_valid`, rd=5, data=0xDEADBEEF -> next cycle `rf_we`=1, `rf_A3`=5, `rf_wd`=0xDEADBEEF; rd=0 -> `rf_we`=0.
- Scoreboard: `issue_valid` rd=7, `A1`=7 -> `hazard1`=1 until cycle after rd=7 result's `rf_we`; `A1`=0 -> `hazard1`=0 always.
- Priority: `core_valid` for 6 cycles while 5 lu results (rd 1..5) arrive, `FIFO_DEPTH`=4 -> `lu_ready`=0 after 4th push, 5th waits; afterwards rd 1,2,3,4,5 written in order on consecutive cycles.
- Same-cycle set/clear: pop of rd=9 coincident with `issue_valid` rd=9 -> `busy[9]` remains 1, `hazard` stays 1.
- Bypass: with `RF_WB_LU_BYPASS_EN`, idle FIFO, lu rd=3 at N -> `rf_we` at N+1; without macro -> `rf_we` at N+2.
